// File: rtl/fixedpoint_alu_pkg.sv
// Shared constants, op encoding and flag helper for the sign-magnitude Q7.8 ALU.
// Pure declarations; no logic.
`timescale 1ns/1ps
package fxp_alu_pkg;

   localparam int WIDTH     = 16;
   localparam int FRAC_BITS = 8;
   localparam int MAG_W     = 15;
   localparam logic [MAG_W-1:0] MAG_MAX = 15'h7FFF;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_MUL = 1'b1
   } op_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] res,
                                             input logic c, input logic v);
      logic [3:0] f;
      f         = 4'b0000;
      f[FLAG_N] = res[WIDTH-1];
      f[FLAG_Z] = (res == '0);
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/fixedpoint_alu_if.sv
// Operand/result bundle for the fixed-point ALU; master drives operands, slave returns results.
// No handshake: one operation per clock, result valid one cycle after the operand edge.
`timescale 1ns/1ps
interface fixedpoint_alu_if;
   import fxp_alu_pkg::*;

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             alu_control;
   logic [WIDTH-1:0] res;
   logic [3:0]       flags;

   modport master (output a, b, alu_control, input res, flags);
   modport slave  (input a, b, alu_control, output res, flags);

endinterface

// File: rtl/fixedpoint_alu_mul.sv
// Magnitude multiply for Q7.8: 15x15 product, truncating >>8, saturate detect. Combinational.
// No backpressure; output follows inputs within the cycle.
`timescale 1ns/1ps
module fxp_sm_mul
   import fxp_alu_pkg::*;
(
   input  logic [MAG_W-1:0] mag_a,
   input  logic [MAG_W-1:0] mag_b,
   output logic [MAG_W-1:0] mag,
   output logic             ovf
);

   logic [2*MAG_W-1:0] product;
   logic [2*MAG_W-1:0] shifted;

   assign product = {{MAG_W{1'b0}}, mag_a} * {{MAG_W{1'b0}}, mag_b};
   assign shifted = product >> FRAC_BITS;

   // Anything above the 15 magnitude bits after the shift cannot be represented.
   assign ovf = |shifted[2*MAG_W-1:MAG_W];
   assign mag = ovf ? MAG_MAX : shifted[MAG_W-1:0];

endmodule

// File: rtl/fixedpoint_alu.sv
// Sign-magnitude Q7.8 add/multiply with saturation; result and {N,Z,C,V} registered, latency 1.
// No handshake or backpressure: a new operation is accepted every clock.
`timescale 1ns/1ps
module fixedpoint_alu
   import fxp_alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             alu_control,
   output logic [WIDTH-1:0] res,
   output logic [3:0]       flags
);

   logic [MAG_W-1:0] mag_a, mag_b;
   logic             sgn_a, sgn_b;
   op_e              op;

   // A zero magnitude always counts as positive, so 0x8000 behaves like 0x0000.
   assign mag_a = a[MAG_W-1:0];
   assign mag_b = b[MAG_W-1:0];
   assign sgn_a = a[WIDTH-1] & (|mag_a);
   assign sgn_b = b[WIDTH-1] & (|mag_b);
   assign op    = op_e'(alu_control);

   logic [MAG_W:0]   add_sum;
   logic [MAG_W-1:0] add_mag;
   logic             add_sgn, add_c, add_v;

   always_comb begin
      add_sum = {1'b0, mag_a} + {1'b0, mag_b};
      add_mag = '0;
      add_sgn = 1'b0;
      add_c   = 1'b0;
      add_v   = 1'b0;
      if (sgn_a == sgn_b) begin
         add_sgn = sgn_a;
         add_c   = add_sum[MAG_W];
         add_v   = add_sum[MAG_W];
         add_mag = add_sum[MAG_W] ? MAG_MAX : add_sum[MAG_W-1:0];
      end else if (mag_a >= mag_b) begin
         add_sgn = sgn_a;
         add_mag = mag_a - mag_b;
      end else begin
         add_sgn = sgn_b;
         add_mag = mag_b - mag_a;
      end
   end

   logic [MAG_W-1:0] mul_mag;
   logic             mul_ovf;

   fxp_sm_mul u_mul (
      .mag_a (mag_a),
      .mag_b (mag_b),
      .mag   (mul_mag),
      .ovf   (mul_ovf)
   );

   logic [MAG_W-1:0] sel_mag;
   logic             sel_sgn, sel_c, sel_v;
   logic [WIDTH-1:0] res_nxt;
   logic [3:0]       flags_nxt;

   always_comb begin
      sel_mag = add_mag;
      sel_sgn = add_sgn;
      sel_c   = add_c;
      sel_v   = add_v;
      if (op == OP_MUL) begin
         sel_mag = mul_mag;
         sel_sgn = sgn_a ^ sgn_b;
         sel_c   = 1'b0;
         sel_v   = mul_ovf;
      end
      // Suppress negative zero on the way out.
      res_nxt   = {sel_sgn & (|sel_mag), sel_mag};
      flags_nxt = make_flags(res_nxt, sel_c, sel_v);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res   <= '0;
         flags <= '0;
      end else begin
         res   <= res_nxt;
         flags <= flags_nxt;
      end
   end

endmodule

// File: tb/tb_fixedpoint_alu.sv
// Directed-vector bench for fixedpoint_alu with hand-computed results and flags.
`timescale 1ns/1ps
module tb_fixedpoint_alu;

   typedef struct {
      string       name;
      logic [15:0] a;
      logic [15:0] b;
      logic        op;
      logic [15:0] r;
      logic [3:0]  f;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   fixedpoint_alu_if bus ();

   fixedpoint_alu dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .a           (bus.a),
      .b           (bus.b),
      .alu_control (bus.alu_control),
      .res         (bus.res),
      .flags       (bus.flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic apply(input logic [15:0] va, input logic [15:0] vb, input logic vop);
      @(negedge clk);
      bus.a           = va;
      bus.b           = vb;
      bus.alu_control = vop;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n           = 1'b1;
      bus.a           = 16'h7F00;
      bus.b           = 16'h7F00;
      bus.alu_control = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      n_vec++;
      if (bus.res !== 16'h0000 || bus.flags !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_async: res=%h flags=%b required res=0000 flags=0000", bus.res, bus.flags);
      end
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if (bus.res !== 16'h0000 || bus.flags !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_hold: res=%h flags=%b required res=0000 flags=0000", bus.res, bus.flags);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add;
      vec_t v[7];
      v = '{
         '{"add_mixed",      16'hE0C0, 16'h3290, 1'b0, 16'hAE30, 4'b1000},
         '{"add_pos",        16'h0180, 16'h0240, 1'b0, 16'h03C0, 4'b0000},
         '{"add_neg",        16'h8100, 16'h8080, 1'b0, 16'h8180, 4'b1000},
         '{"add_b_larger",   16'h0100, 16'h8300, 1'b0, 16'h8200, 4'b1000},
         '{"add_cancel",     16'h0100, 16'h8100, 1'b0, 16'h0000, 4'b0100},
         '{"add_negzero",    16'h8000, 16'h8000, 1'b0, 16'h0000, 4'b0100},
         '{"add_negzero_b",  16'h8000, 16'h0100, 1'b0, 16'h0100, 4'b0000}
      };
      foreach (v[i]) begin
         apply(v[i].a, v[i].b, v[i].op);
         n_vec++;
         if (bus.res !== v[i].r || bus.flags !== v[i].f) begin
            n_err++;
            $display("FAIL %s: res=%h flags=%b required res=%h flags=%b",
                     v[i].name, bus.res, bus.flags, v[i].r, v[i].f);
         end
      end
   endtask

   task automatic test_mul;
      vec_t v[7];
      v = '{
         '{"mul_neg_pos",    16'hE0C0, 16'h0090, 1'b1, 16'hB66C, 4'b1000},
         '{"mul_neg_neg",    16'hE0C0, 16'h8090, 1'b1, 16'h366C, 4'b0000},
         '{"mul_pos_pos",    16'h60C0, 16'h0090, 1'b1, 16'h366C, 4'b0000},
         '{"mul_one",        16'h0100, 16'h0100, 1'b1, 16'h0100, 4'b0000},
         '{"mul_max_exact",  16'h7FFF, 16'h0100, 1'b1, 16'h7FFF, 4'b0000},
         '{"mul_zero_sign",  16'h8100, 16'h0000, 1'b1, 16'h0000, 4'b0100},
         '{"mul_trunc_zero", 16'h8001, 16'h0001, 1'b1, 16'h0000, 4'b0100}
      };
      foreach (v[i]) begin
         apply(v[i].a, v[i].b, v[i].op);
         n_vec++;
         if (bus.res !== v[i].r || bus.flags !== v[i].f) begin
            n_err++;
            $display("FAIL %s: res=%h flags=%b required res=%h flags=%b",
                     v[i].name, bus.res, bus.flags, v[i].r, v[i].f);
         end
      end
   endtask

   task automatic test_overflow;
      vec_t v[4];
      v = '{
         '{"add_ovf_pos", 16'h7F00, 16'h7F00, 1'b0, 16'h7FFF, 4'b0011},
         '{"add_ovf_neg", 16'hC000, 16'hC000, 1'b0, 16'hFFFF, 4'b1011},
         '{"mul_ovf_pos", 16'h4000, 16'h0400, 1'b1, 16'h7FFF, 4'b0001},
         '{"mul_ovf_neg", 16'hC000, 16'h0400, 1'b1, 16'hFFFF, 4'b1001}
      };
      foreach (v[i]) begin
         apply(v[i].a, v[i].b, v[i].op);
         n_vec++;
         if (bus.res !== v[i].r || bus.flags !== v[i].f) begin
            n_err++;
            $display("FAIL %s: res=%h flags=%b required res=%h flags=%b",
                     v[i].name, bus.res, bus.flags, v[i].r, v[i].f);
         end
      end
   endtask

   // Alternating ops on consecutive edges: each result must reflect only its own inputs.
   task automatic test_back_to_back;
      vec_t v[5];
      v = '{
         '{"b2b_0", 16'h0180, 16'h0240, 1'b0, 16'h03C0, 4'b0000},
         '{"b2b_1", 16'hE0C0, 16'h0090, 1'b1, 16'hB66C, 4'b1000},
         '{"b2b_2", 16'h7F00, 16'h7F00, 1'b0, 16'h7FFF, 4'b0011},
         '{"b2b_3", 16'h0100, 16'h0100, 1'b1, 16'h0100, 4'b0000},
         '{"b2b_4", 16'h0100, 16'h8100, 1'b0, 16'h0000, 4'b0100}
      };
      foreach (v[i]) begin
         apply(v[i].a, v[i].b, v[i].op);
         n_vec++;
         if (bus.res !== v[i].r || bus.flags !== v[i].f) begin
            n_err++;
            $display("FAIL %s: res=%h flags=%b required res=%h flags=%b",
                     v[i].name, bus.res, bus.flags, v[i].r, v[i].f);
         end
      end
   endtask

   task automatic test_reset_midstream;
      apply(16'hE0C0, 16'h3290, 1'b0);
      n_vec++;
      if (bus.res !== 16'hAE30 || bus.flags !== 4'b1000) begin
         n_err++;
         $display("FAIL mid_pre: res=%h flags=%b required res=ae30 flags=1000", bus.res, bus.flags);
      end
      @(negedge clk);
      bus.a           = 16'h7F00;
      bus.b           = 16'h7F00;
      bus.alu_control = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (bus.res !== 16'h0000 || bus.flags !== 4'b0000) begin
         n_err++;
         $display("FAIL mid_async: res=%h flags=%b required res=0000 flags=0000", bus.res, bus.flags);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (bus.res !== 16'h0000 || bus.flags !== 4'b0000) begin
         n_err++;
         $display("FAIL mid_discard: res=%h flags=%b required res=0000 flags=0000", bus.res, bus.flags);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_vec++;
      if (bus.res !== 16'h7FFF || bus.flags !== 4'b0011) begin
         n_err++;
         $display("FAIL mid_resume: res=%h flags=%b required res=7fff flags=0011", bus.res, bus.flags);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_add();
      test_mul();
      test_overflow();
      test_back_to_back();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fixedpoint_alu.md
FIXEDPOINT_ALU -- requirements
Module: fixedpoint_alu

Interface
REQ-001 The module SHALL have no parameters; word width 16 and fraction bits 8 are fixed package constants.
REQ-002 The module SHALL have port `clk`: input, 1 bit, rising-edge clock.
REQ-003 The module SHALL have port `rst_n`: input, 1 bit, asynchronous active-low reset.
REQ-004 The module SHALL have port `a`: input, 16 bits, operand A, sign-magnitude Q7.8 (bit15 sign, bits14:8 integer, bits7:0 fraction).
REQ-005 The module SHALL have port `b`: input, 16 bits, operand B, same format as `a`.
REQ-006 The module SHALL have port `alu_control`: input, 1 bit, operation select: 0 = add, 1 = multiply.
REQ-007 The module SHALL have port `res`: output, 16 bits, registered result in sign-magnitude Q7.8.
REQ-008 The module SHALL have port `flags`: output, 4 bits, registered flags {N,Z,C,V} (bit3 = N, bit2 = Z, bit1 = C, bit0 = V).

Function
REQ-009 The module SHALL sample `a`, `b` and `alu_control` at each rising `clk` edge.
REQ-010 The module SHALL present `res` and `flags` for those inputs after that same edge (latency 1 cycle, one result per cycle, no handshake).
REQ-011 For add with equal signs, the result magnitude SHALL be |a|+|b| (16-bit internal) with the common sign; C SHALL be the carry out of bit 14.
REQ-012 For add with different signs, the result magnitude SHALL be larger minus smaller, with the sign of the larger magnitude; C = 0.
REQ-013 On add, if the magnitude exceeds 0x7FFF, the result SHALL saturate to magnitude 0x7FFF with the operand sign, and V = 1.
REQ-014 For multiply, the result sign SHALL be sign(a) XOR sign(b).
REQ-015 For multiply, the 30-bit product |a|*|b| SHALL be shifted right by 8 (truncation toward zero), and C SHALL be 0.
REQ-016 On multiply, if the shifted product exceeds 0x7FFF, the result SHALL saturate to 0x7FFF with the product sign, and V = 1.
REQ-017 A zero magnitude result SHALL be emitted as 0x0000 (no negative zero), with Z = 1 and N = 0.
REQ-018 N SHALL equal `res[15]`, and Z SHALL be 1 iff `res` equals 0x0000.
REQ-019 Negative-zero inputs (0x8000) SHALL be treated as zero.
REQ-020 The datapath SHALL be purely combinational between the input sample and the output register; there SHALL be no state machine.

Reset
REQ-021 While `rst_n` = 0, asynchronously, `res` SHALL be 0x0000 and `flags` SHALL be 0000.
REQ-022 Operation SHALL resume on the first rising edge after `rst_n` deasserts.
REQ-023 A reset asserted mid-stream SHALL discard the pending result.

Structure
REQ-024 Package `fxp_alu_pkg` SHALL hold WIDTH=16, FRAC_BITS=8, MAG_W=15, MAG_MAX=15'h7FFF.
REQ-025 Package `fxp_alu_pkg` SHALL hold the op enum OP_ADD=1'b0, OP_MUL=1'b1.
REQ-026 Package `fxp_alu_pkg` SHALL hold the flag bit index constants.
REQ-027 One sub-module `fxp_sm_mul` SHALL perform the magnitude multiply, shift, and saturation detection; add logic and the output register SHALL live in the top.

Verification
REQ-028 Add: a=0xE0C0 (-96.75), b=0x3290 (+50.5625) -> res=0xAE30 (-46.1875), flags=1000.
REQ-029 Mul (- * +): a=0xE0C0, b=0x0090 (0.5625) -> res=0xB66C (-54.421875), flags=1000.
REQ-030 Mul (- * -) and (+ * +): a=0xE0C0, b=0x8090 -> res=0x366C, flags=0000; a=0x60C0, b=0x0090 -> res=0x366C, flags=0000.
REQ-031 Add overflow: a=0x7F00, b=0x7F00 -> res=0x7FFF, flags=0011.
REQ-032 Mul overflow: a=0x4000, b=0x0400 -> res=0x7FFF, flags=0001.
REQ-033 Add cancellation: a=0x0100, b=0x8100 -> res=0x0000, flags=0100.
REQ-034 Reset: assert `rst_n`=0 mid-stream -> res=0x0000 and flags=0000 immediately, without waiting for a clock edge.
